// File: rtl/la_ioring_pkg.sv
// Shared types and constants for the io-ring configuration master.
package la_ioring_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH,
    ST_DONE
  } state_t;

  // Bit positions on the io-ring bus
  localparam int SCLK  = 0;
  localparam int SDO   = 1;
  localparam int LATCH = 2;
  localparam int SDI   = 3;

  function automatic int chain_len(input int npads, input int cfgw);
    return npads * cfgw;
  endfunction

endpackage

// File: rtl/la_ioring_phase.sv
// Phase timer: loads P-1 on start, counts down while run is high and
// pulses phase_end on the last cycle of every P-cycle phase.
module la_ioring_phase #(
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            run,
  input  logic [DIVW-1:0] div,
  output logic            phase_end
);

  logic [DIVW-1:0] period;
  logic [DIVW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      period <= '0;
      cnt    <= '0;
    end else if (start) begin
      period <= div;
      cnt    <= div;
    end else if (run) begin
      if (cnt == '0) cnt <= period;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign phase_end = run && (cnt == '0);

endmodule

// File: rtl/la_ioring_cfg.sv
// Io-ring configuration master: shadow image, serial chain load, latch pulse.
// Optional readback check of the chain return is enabled by LA_IORING_READBACK_EN.
module la_ioring_cfg
  import la_ioring_pkg::*;
#(
  parameter int RINGW = 8,
  parameter int NPADS = 16,
  parameter int CFGW  = 4,
  parameter int DIVW  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [$clog2(NPADS)-1:0] cfg_addr,
  input  logic [CFGW-1:0]          cfg_data,
  input  logic                     go,
  input  logic [DIVW-1:0]          div,
  output logic                     busy,
  output logic                     done,
  output logic [RINGW-1:0]         ioring_out,
  input  logic [RINGW-1:0]         ioring_in
`ifdef LA_IORING_READBACK_EN
  ,
  output logic                     err
`endif
);

  localparam int N  = chain_len(NPADS, CFGW);
  localparam int AW = $clog2(NPADS);
  localparam int IW = $clog2(N);

  state_t        state, state_nxt;
  logic [N-1:0]  image;
  logic [IW-1:0] idx;
  logic          phase_end;
  logic          run;
  logic          start;
  logic          wr_en;
  logic          last_bit;

  assign cfg_ready = (state == ST_IDLE);
  assign wr_en     = cfg_valid && cfg_ready;
  assign start     = go && (state == ST_IDLE);
  assign run       = state inside {ST_SHIFT_LO, ST_SHIFT_HI, ST_LATCH};
  assign busy      = run;
  assign done      = (state == ST_DONE);
  assign last_bit  = (idx == '0);

  la_ioring_phase #(.DIVW(DIVW)) u_phase (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .run       (run),
    .div       (div),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets its default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_SHIFT_LO;
      ST_SHIFT_LO: if (phase_end) state_nxt = ST_SHIFT_HI;
      ST_SHIFT_HI: if (phase_end) state_nxt = last_bit ? ST_LATCH : ST_SHIFT_LO;
      ST_LATCH:    if (phase_end) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Chain order: image bit N-1 (pad NPADS-1 MSB) goes out first
  always_ff @(posedge clk) begin
    if (reset)                                         idx <= '0;
    else if (start)                                    idx <= IW'(N - 1);
    else if (state == ST_SHIFT_HI && phase_end && !last_bit) idx <= idx - 1'b1;
  end

  // NOTE: the shadow image is reset on purpose so a reset never leaves stale
  // pad settings waiting for the next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      image <= '0;
    end else if (wr_en) begin
      for (int p = 0; p < NPADS; p++) begin
        if (cfg_addr == AW'(p)) image[p*CFGW +: CFGW] <= cfg_data;
      end
    end
  end

  always_comb begin
    ioring_out        = '0;
    ioring_out[SCLK]  = (state == ST_SHIFT_HI);
    ioring_out[SDO]   = (state == ST_SHIFT_LO || state == ST_SHIFT_HI) && image[idx];
    ioring_out[LATCH] = (state == ST_LATCH);
  end

`ifdef LA_IORING_READBACK_EN
  logic [N-1:0] copy;
  logic         have_copy;
  logic         sdi;
  logic         unused_ring;

  assign sdi         = ioring_in[SDI];
  assign unused_ring = ^(ioring_in & ~(RINGW'(1) << SDI));

  always_ff @(posedge clk) begin
    if (reset) begin
      have_copy <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (start) err <= 1'b0;
      else if (state == ST_SHIFT_HI && phase_end && have_copy && sdi != copy[idx]) err <= 1'b1;
      if (state == ST_DONE) have_copy <= 1'b1;
    end
  end

  // Qualified by have_copy, so the copy itself needs no reset
  always_ff @(posedge clk) begin
    if (state == ST_DONE) copy <= image;
  end
`else
  logic unused_ring;
  assign unused_ring = ^ioring_in;
`endif

endmodule

// File: tb/tb_la_ioring_cfg.sv
// Self-checking bench for la_ioring_cfg: per-cycle ring waveform checked
// against an arithmetic model of the shadow image and chain timing.
module tb_la_ioring_cfg;

  localparam int RINGW   = 8;
  localparam int NPADS   = 16;
  localparam int CFGW    = 4;
  localparam int DIVW    = 8;
  localparam int N       = NPADS * CFGW;
  localparam int AW      = $clog2(NPADS);
  localparam int NPADS_B = 12;
  localparam int N_B     = NPADS_B * CFGW;
  localparam int AW_B    = $clog2(NPADS_B);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             cfg_valid, cfg_ready, go, busy, done;
  logic [AW-1:0]    cfg_addr;
  logic [CFGW-1:0]  cfg_data;
  logic [DIVW-1:0]  div;
  logic [RINGW-1:0] ioring_out, ioring_in;

  logic             b_valid, b_ready, b_go, b_busy, b_done;
  logic [AW_B-1:0]  b_addr;
  logic [CFGW-1:0]  b_data;
  logic [DIVW-1:0]  b_div;
  logic [RINGW-1:0] b_ring_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CFGW-1:0] model_img [NPADS];

`ifdef LA_IORING_READBACK_EN
  logic err, b_err;
  logic [N-1:0] chain = '0;
  logic sdi_q = 1'b0;
  int rx_cnt = 0;
  int flip_at = -1;

  // 64-stage pad chain with an output flop; flip_at corrupts one returned bit
  always @(posedge ioring_out[0]) begin
    sdi_q  <= chain[N-1] ^ (rx_cnt == flip_at);
    chain  <= {chain[N-2:0], ioring_out[1]};
    rx_cnt <= rx_cnt + 1;
  end
  assign ioring_in = RINGW'({sdi_q, 3'b000});
`else
  assign ioring_in = '0;
`endif

  la_ioring_cfg #(.RINGW(RINGW), .NPADS(NPADS), .CFGW(CFGW), .DIVW(DIVW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .go         (go),
    .div        (div),
    .busy       (busy),
    .done       (done),
    .ioring_out (ioring_out),
    .ioring_in  (ioring_in)
`ifdef LA_IORING_READBACK_EN
    ,
    .err        (err)
`endif
  );

  la_ioring_cfg #(.RINGW(RINGW), .NPADS(NPADS_B), .CFGW(CFGW), .DIVW(DIVW)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (b_valid),
    .cfg_ready  (b_ready),
    .cfg_addr   (b_addr),
    .cfg_data   (b_data),
    .go         (b_go),
    .div        (b_div),
    .busy       (b_busy),
    .done       (b_done),
    .ioring_out (b_ring_out),
    .ioring_in  ('0)
`ifdef LA_IORING_READBACK_EN
    ,
    .err        (b_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {done, busy, latch, sdo, sclk} in cycle c after the go edge
  function automatic logic [4:0] expect_cycle(input int c, input int p, input int nbits,
                                              input logic [63:0] sv);
    int   j;
    logic hi;
    if (c <= 2 * nbits * p) begin
      j  = (c - 1) / (2 * p);
      hi = ((c - 1) % (2 * p)) >= p;
      return {2'b01, 1'b0, sv[j], hi};
    end else if (c <= 2 * nbits * p + p) begin
      return 5'b01100;
    end
    return 5'b10000;
  endfunction

  task automatic write_cfg(input int addr, input logic [CFGW-1:0] data);
    cfg_valid = 1'b1;
    cfg_addr  = AW'(addr);
    cfg_data  = data;
    #1 check("wr ready", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    if (addr < NPADS) model_img[addr] = data;
  endtask

  task automatic run_pass(input int divv, input bit noise, input bit wr,
                          input int wr_addr, input logic [CFGW-1:0] wr_data);
    logic [63:0] sv;
    logic [4:0]  e;
    int          p, len;
    if (wr) begin
      cfg_valid = 1'b1;
      cfg_addr  = AW'(wr_addr);
      cfg_data  = wr_data;
      model_img[wr_addr] = wr_data;
    end
    go  = 1'b1;
    div = DIVW'(divv);
    sv  = '0;
    for (int j = 0; j < N; j++) sv[j] = model_img[NPADS - 1 - j / CFGW][CFGW - 1 - j % CFGW];
    @(posedge clk); #1;
    go = 1'b0;
    cfg_valid = 1'b0;
    p   = divv + 1;
    len = 2 * N * p + p + 1;
    for (int c = 1; c <= len; c++) begin
      e = expect_cycle(c, p, N, sv);
      check($sformatf("cyc %0d P=%0d", c, p), 32'({cfg_ready, done, busy, ioring_out}),
            32'({1'b0, e[4:3], 5'b0, e[2:0]}));
      if (noise && c < len) begin
        go        = 1'($urandom_range(0, 1));
        cfg_valid = 1'($urandom_range(0, 1));
        cfg_addr  = AW'($urandom);
        cfg_data  = CFGW'($urandom);
        div       = DIVW'($urandom);
      end else begin
        go        = 1'b0;
        cfg_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("idle after done", 32'({cfg_ready, done, busy, ioring_out}), 32'h400);
  endtask

  initial begin
    logic [4:0]  e;
    logic [63:0] svb;
    reset = 1'b1;
    cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; go = 1'b0; div = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0; b_go = 1'b0; b_div = '0;
    for (int k = 0; k < NPADS; k++) model_img[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset state", 32'({cfg_ready, done, busy, ioring_out}), 32'h400);
    check("reset state b", 32'({b_ready, b_done, b_busy, b_ring_out}), 32'h400);
    reset = 1'b0;

    // Empty image, fastest ring clock
    run_pass(0, 1'b0, 1'b0, 0, '0);

    // Directed corner pads
    write_cfg(15, 4'hA);
    write_cfg(0, 4'h5);
    run_pass(3, 1'b0, 1'b0, 0, '0);

    // Random image, then writes/go/div noise during busy, then a clean re-check
    for (int k = 0; k < 8; k++) write_cfg($urandom_range(0, NPADS - 1), CFGW'($urandom));
    run_pass($urandom_range(0, 2), 1'b1, 1'b0, 0, '0);
    run_pass(1, 1'b0, 1'b0, 0, '0);

    // Write and go in the same cycle
    run_pass(0, 1'b0, 1'b1, $urandom_range(0, NPADS - 1), CFGW'($urandom));

    // Reset in the middle of a SHIFT_HI phase
    go = 1'b1; div = 8'd1;
    @(posedge clk); #1;
    go = 1'b0;
    for (int c = 1; c < 23; c++) begin
      @(posedge clk); #1;
    end
    check("mid shift sclk", 32'(ioring_out[0]), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset abort", 32'({cfg_ready, done, busy, ioring_out}), 32'h400);
    reset = 1'b0;
    for (int k = 0; k < NPADS; k++) model_img[k] = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check($sformatf("quiet after abort %0d", c), 32'({cfg_ready, done, busy, ioring_out}), 32'h400);
    end
    run_pass(0, 1'b0, 1'b0, 0, '0);

    // Out-of-range addresses on a 12-pad chain are handshaken and dropped
    for (int a = 11; a < 16; a++) begin
      b_valid = 1'b1;
      b_addr  = AW_B'(a);
      b_data  = (a == 11) ? 4'h9 : 4'hF;
      #1 check($sformatf("b wr ready %0d", a), 32'(b_ready), 32'd1);
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    svb = '0;
    svb[0] = 1'b1;
    svb[3] = 1'b1;
    b_go = 1'b1; b_div = '0;
    @(posedge clk); #1;
    b_go = 1'b0;
    for (int c = 1; c <= 2 * N_B + 2; c++) begin
      e = expect_cycle(c, 1, N_B, svb);
      check($sformatf("b cyc %0d", c), 32'({b_done, b_busy, b_ring_out}),
            32'({e[4:3], 5'b0, e[2:0]}));
      @(posedge clk); #1;
    end

`ifdef LA_IORING_READBACK_EN
    for (int k = 0; k < NPADS; k++) write_cfg(k, CFGW'($urandom));
    run_pass(0, 1'b0, 1'b0, 0, '0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < NPADS; k++) model_img[k] = '0;
    for (int k = 0; k < NPADS; k++) write_cfg(k, CFGW'($urandom));
    flip_at = rx_cnt + 3;
    run_pass(0, 1'b0, 1'b0, 0, '0);
    check("err first pass", 32'(err), 32'd0);
    flip_at = -1;
    run_pass(1, 1'b0, 1'b0, 0, '0);
    check("err matched pass", 32'(err), 32'd0);
    flip_at = rx_cnt + 7;
    run_pass(0, 1'b0, 1'b0, 0, '0);
    check("err flipped bit", 32'(err), 32'd1);
    flip_at = -1;
    run_pass(0, 1'b0, 1'b0, 0, '0);
    check("err cleared", 32'(err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
